spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter READ_CMD, default 8'h03, the read opcode sent when fast read is compiled out.
REQ-002 SHALL have parameter CS_GAP_CYCLES, default 4, the minimum clk cycles spiCs stays high after a transaction.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a read, sampled only in IDLE.
REQ-006 SHALL have port address, input, 24, the flash start address, captured on an accepted start.
REQ-007 SHALL have port length, input, 16, the number of data bytes to read, captured on an accepted start.
REQ-008 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the read completes.
REQ-010 SHALL have port spiCs, output, 1, the active-low flash chip select.
REQ-011 SHALL have port spiTxData, output, 8, the byte to the SPI controller.
REQ-012 SHALL have port spiTxValid, output, 1, which qualifies spiTxData.
REQ-013 SHALL have port spiReady, input, 1, the SPI controller ready (idle) flag.
REQ-014 SHALL have port spiRxData, input, 8, the byte received by the SPI controller.
REQ-015 SHALL have ports outData (output, 8) and outValid (output, 1), where outValid is a one-cycle write strobe to the downstream FIFO.
REQ-016 SHALL have port outFull, input, 1, the downstream FIFO full flag (backpressure).

Function
REQ-017 SHALL implement states IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, CS_GAP.
REQ-018 IDLE, start=1, length!=0: SHALL capture address and length, drive spiCs<=0 and busy<=1, then go to LOAD.
REQ-019 IDLE, start=1, length=0: SHALL pulse done the next cycle, leave spiCs high, and issue no SPI traffic.
REQ-020 Byte sequence: opcode, address[23:16], address[15:8], address[7:0], [dummy 8'h00 if fast read], then length bytes of 8'h00 filler.
REQ-021 SEND: when spiReady=1, SHALL drive spiTxData with the next sequence byte, set spiTxValid=1, and go to WAIT_ACK.
REQ-022 WAIT_ACK: on spiReady=0, SHALL drop spiTxValid and go to WAIT_DONE; spiTxValid is held high until then.
REQ-023 WAIT_DONE: on spiReady=1, SHALL discard spiRxData for header and dummy bytes.
REQ-024 WAIT_DONE, data bytes: SHALL forward spiRxData to outData with a one-cycle outValid, only when outFull=0; otherwise wait in WAIT_DONE holding the byte.
REQ-025 After the last data byte is forwarded: spiCs<=1, go to CS_GAP, count CS_GAP_CYCLES, then pulse done, busy<=0, go to IDLE.
REQ-026 Counters: a 16-bit remaining-byte counter, decremented per forwarded byte; exactly length outValid pulses per request; length=16'hFFFF SHALL not wrap early.
REQ-027 start while busy SHALL be ignored; address and length SHALL not change mid-transaction.
REQ-028 outValid and done SHALL never be asserted in the same cycle.

Reset
REQ-029 On reset: state=IDLE, spiCs=1, spiTxValid=0, spiTxData=0, outValid=0, outData=0, busy=0, done=0, counters=0.
REQ-030 Reset asserted mid-transaction SHALL take effect on the next edge, releasing spiCs immediately; no partial outValid SHALL follow.

Configuration
REQ-031 Macro SPI_FLASH_READER_FAST_READ_EN defined: opcode SHALL be 8'h0B, followed by one dummy byte after the address (5 header bytes), and READ_CMD is ignored.
REQ-032 Macro undefined: opcode SHALL be READ_CMD with no dummy byte (4 header bytes).

Verification
REQ-033 start, address=24'h000000, length=32, SPI model returning bytes 0..35 -> tx bytes 03,00,00,00 then 32x 00; outData sequence 4..35; 32 outValid pulses; done once; spiCs low throughout the transaction.
REQ-034 length=0 -> done one cycle after start, spiCs never low, spiTxValid never high.
REQ-035 outFull held high for 10 cycles after the 3rd data byte -> no outValid during the stall, no data lost, spiTxValid held low, remaining bytes in order.
REQ-036 reset asserted during the 2nd address byte -> next cycle spiCs=1, busy=0, spiTxValid=0; subsequent start runs normally.
REQ-037 FAST_READ_EN defined, address=24'h123456, length=2 -> tx bytes 0B,12,34,56,00,00,00; first 5 rx bytes discarded; 2 outValid pulses.
REQ-038 start pulsed again while busy -> ignored; single done pulse; CS_GAP of at least 4 cycles of spiCs=1 before the next accepted start.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: issues opcode/address, streams data bytes out.
// Define SPI_FLASH_READER_FAST_READ_EN for opcode 0x0B plus one dummy byte.
module spi_flash_reader #(
   parameter logic [7:0] READ_CMD      = 8'h03,
   parameter int         CS_GAP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] address,
   input  logic [15:0] length,
   output logic        busy,
   output logic        done,
   output logic        spiCs,
   output logic [7:0]  spiTxData,
   output logic        spiTxValid,
   input  logic        spiReady,
   input  logic [7:0]  spiRxData,
   output logic [7:0]  outData,
   output logic        outValid,
   input  logic        outFull
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
   localparam logic [7:0] OPCODE    = 8'h0B;
   localparam logic [2:0] HDR_BYTES = 3'd5;
`else
   localparam logic [7:0] OPCODE    = READ_CMD;
   localparam logic [2:0] HDR_BYTES = 3'd4;
`endif

   localparam logic [15:0] GAP_LAST =
      16'((CS_GAP_CYCLES > 0) ? CS_GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, CS_GAP
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [15:0] rem_q, rem_d;
   logic [2:0]  hdr_q, hdr_d;
   logic [15:0] gap_q, gap_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        cs_q, cs_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  hdr_byte;
   logic        in_hdr;

   assign in_hdr = (hdr_q != HDR_BYTES);

   // Header byte for the current header index; dummy and filler are zero.
   always_comb begin
      case (hdr_q)
         3'd0:    hdr_byte = OPCODE;
         3'd1:    hdr_byte = addr_q[23:16];
         3'd2:    hdr_byte = addr_q[15:8];
         3'd3:    hdr_byte = addr_q[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   // Next-state and registered-output logic for the read sequencer.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      hdr_d       = hdr_q;
      gap_d       = gap_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cs_d        = cs_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (length == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d  = address;
                  rem_d   = length;
                  cs_d    = 1'b0;
                  busy_d  = 1'b1;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            hdr_d   = 3'd0;
            state_d = SEND;
         end
         SEND: begin
            if (spiReady) begin
               tx_data_d  = in_hdr ? hdr_byte : 8'h00;
               tx_valid_d = 1'b1;
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!spiReady) begin
               tx_valid_d = 1'b0;
               state_d    = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (spiReady) begin
               if (in_hdr) begin
                  hdr_d   = hdr_q + 3'd1;
                  state_d = SEND;
               end else if (!outFull) begin
                  out_data_d  = spiRxData;
                  out_valid_d = 1'b1;
                  rem_d       = rem_q - 16'd1;
                  if (rem_q == 16'd1) begin
                     cs_d    = 1'b1;
                     gap_d   = 16'd0;
                     state_d = CS_GAP;
                  end else begin
                     state_d = SEND;
                  end
               end
            end
         end
         CS_GAP: begin
            if (gap_q >= GAP_LAST) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= 24'd0;
         rem_q       <= 16'd0;
         hdr_q       <= 3'd0;
         gap_q       <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cs_q        <= 1'b1;
         tx_data_q   <= 8'd0;
         tx_valid_q  <= 1'b0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         hdr_q       <= hdr_d;
         gap_q       <= gap_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cs_q        <= cs_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign spiCs      = cs_q;
   assign spiTxData  = tx_data_q;
   assign spiTxValid = tx_valid_q;
   assign outData    = out_data_q;
   assign outValid   = out_valid_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomized scoreboard bench for spi_flash_reader with an SPI controller
// model and a downstream FIFO backpressure model.
module tb_spi_flash_reader;

   localparam int GAP = 4;
`ifdef SPI_FLASH_READER_FAST_READ_EN
   localparam int         HDR = 5;
   localparam logic [7:0] OPC = 8'h0B;
`else
   localparam int         HDR = 4;
   localparam logic [7:0] OPC = 8'h03;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [23:0] address = '0;
   logic [15:0] length = '0;
   logic        busy, done, spiCs, spiTxValid, outValid;
   logic [7:0]  spiTxData, outData;
   logic        spiReady = 1'b1;
   logic [7:0]  spiRxData = 8'h00;
   logic        outFull = 1'b0;

   always #5 clk = ~clk;

   spi_flash_reader #(.READ_CMD(8'h03), .CS_GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .start(start), .address(address),
      .length(length), .busy(busy), .done(done), .spiCs(spiCs),
      .spiTxData(spiTxData), .spiTxValid(spiTxValid),
      .spiReady(spiReady), .spiRxData(spiRxData), .outData(outData),
      .outValid(outValid), .outFull(outFull)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0] txq[$];
   logic [7:0] outq[$];
   int done_cnt = 0, done_exp = 0;
   logic [7:0] seed = 8'h00, rx_next = 8'h00;
   int tx_idx = 0, abort_at = -1, busy_cnt = 0;
   bit abort_hit = 0;
   int stall_at = -1, full_hold = 0, data_seen = 0, hi_cnt = 1000;
   bit prev_full = 0, prev_cs = 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%0h expected=none", nm, act);
   endtask

   // SPI controller: accepts a byte, goes busy 1..4 cycles, returns
   // seed + byte index as the received byte.
   always @(negedge clk) begin
      if (reset) begin
         spiReady = 1'b1;
         busy_cnt = 0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            spiRxData = rx_next;
            spiReady  = 1'b1;
         end
      end else if (spiReady && spiTxValid) begin
         if (txq.size() == 0) flag("tx_extra", spiTxData);
         else chk("tx_byte", spiTxData, txq.pop_front());
         chk("tx_cs_low", spiCs, 0);
         if (tx_idx == abort_at) abort_hit = 1;
         rx_next  = seed + 8'(tx_idx);
         tx_idx++;
         spiReady = 1'b0;
         busy_cnt = $urandom_range(1, 4);
      end
   end

   // Output monitor, CS gap checker and FIFO-full driver.
   always @(negedge clk) begin
      if (reset) begin
         hi_cnt  = 1000;
         prev_cs = 1;
      end else begin
         if (outValid) begin
            chk("out_while_full", prev_full, 0);
            chk("out_with_done", done, 0);
            if (outq.size() == 0) flag("out_extra", outData);
            else chk("out_data", outData, outq.pop_front());
            data_seen++;
            if (data_seen == stall_at) full_hold = 10;
         end
         if (done) done_cnt++;
         if (spiCs) hi_cnt++;
         else begin
            if (prev_cs) begin
               checks++;
               if (hi_cnt < GAP) begin
                  failures++;
                  $display("FAIL cs_gap actual=%0d required>=%0d",
                           hi_cnt, GAP);
               end
            end
            hi_cnt = 0;
         end
         prev_cs = spiCs;
      end
      if (full_hold > 0) begin
         outFull = 1'b1;
         full_hold--;
      end else begin
         outFull = ($urandom_range(0, 3) == 0);
      end
      prev_full = outFull;
   end

   task automatic run(input logic [23:0] addr, input logic [15:0] len,
                      input logic [7:0] sd, input int stall,
                      input int abort, input bit dbl);
      int bound;
      @(negedge clk);
      bound = 0;
      while (busy && bound < 20000) begin
         @(negedge clk);
         bound++;
      end
      if (busy) flag("idle_timeout", bound);
      seed      = sd;
      tx_idx    = 0;
      data_seen = 0;
      stall_at  = stall;
      abort_at  = abort;
      abort_hit = 0;
      if (len != 16'd0) begin
         txq.push_back(OPC);
         txq.push_back(addr[23:16]);
         txq.push_back(addr[15:8]);
         txq.push_back(addr[7:0]);
         if (HDR == 5) txq.push_back(8'h00);
         for (int j = 0; j < int'(len); j++) begin
            txq.push_back(8'h00);
            outq.push_back(sd + 8'(HDR + j));
         end
      end
      if (abort < 0) done_exp++;
      address = addr;
      length  = len;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      address = 24'($urandom);
      length  = 16'($urandom);
      if (len == 16'd0) begin
         chk("len0_done", done, 1);
         chk("len0_cs", spiCs, 1);
         chk("len0_busy", busy, 0);
      end else begin
         chk("busy_set", busy, 1);
         chk("cs_low", spiCs, 0);
      end
      if (abort >= 0) begin
         bound = 0;
         while (!abort_hit && bound < 2000) begin
            @(negedge clk);
            bound++;
         end
         if (!abort_hit) flag("abort_timeout", bound);
         reset = 1'b1;
         @(negedge clk);
         chk("rst_cs", spiCs, 1);
         chk("rst_busy", busy, 0);
         chk("rst_txv", spiTxValid, 0);
         chk("rst_outv", outValid, 0);
         @(negedge clk);
         reset = 1'b0;
         txq.delete();
         outq.delete();
         abort_at = -1;
      end else begin
         if (dbl) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         bound = 0;
         while (done_cnt < done_exp && bound < 30000) begin
            @(negedge clk);
            bound++;
         end
         if (done_cnt < done_exp) flag("done_timeout", bound);
         repeat (2) @(negedge clk);
         chk("done_count", done_cnt, done_exp);
         chk("tx_left", txq.size(), 0);
         chk("out_left", outq.size(), 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_cs", spiCs, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_txv", spiTxValid, 0);
      chk("reset_txd", spiTxData, 0);
      chk("reset_outv", outValid, 0);
      chk("reset_outd", outData, 0);
      reset = 1'b0;
      run(24'h000000, 16'd32, 8'h00, -1, -1, 0);
      run(24'h123456, 16'd2, 8'($urandom), -1, -1, 0);
      run(24'($urandom), 16'd0, 8'($urandom), -1, -1, 0);
      run(24'($urandom), 16'd20, 8'($urandom), 3, -1, 0);
      run(24'($urandom), 16'd10, 8'($urandom), -1, 2, 0);
      run(24'($urandom), 16'd5, 8'($urandom), -1, -1, 1);
      for (int i = 0; i < 10; i++) begin
         run(24'($urandom), 16'($urandom_range(0, 40)), 8'($urandom),
             int'($urandom_range(0, 6)) - 1, -1, 1'($urandom));
      end
      run(24'($urandom), 16'd300, 8'($urandom), 100, -1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
